// File: rtl/lut_eval_seq_if.sv
// Stream and serial-configuration signals of the programmable N-input truth-table evaluator.
// The master side is the harness; the slave side is lut_eval_seq.
interface lut_eval_seq_if #(
    parameter int N_IN = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out;
    logic            cfg_start;
    logic            cfg_abort;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            cfg_bit;
    logic            cfg_done;
    logic            loading;

    modport master (
        output in_valid, in_vec, out_ready, cfg_start, cfg_abort, cfg_valid, cfg_bit,
        input  in_ready, out_valid, out, cfg_ready, cfg_done, loading
    );

    modport slave (
        input  in_valid, in_vec, out_ready, cfg_start, cfg_abort, cfg_valid, cfg_bit,
        output in_ready, out_valid, out, cfg_ready, cfg_done, loading
    );
endinterface

// File: rtl/lut_eval_seq.sv
// N-input Boolean function with a run-time programmable truth table.
// The table is loaded serially into a shadow copy; evaluation always reads the active copy.
module lut_eval_seq #(
    parameter int                     N_IN       = 3,
    parameter logic [(1<<N_IN)-1:0]   TT_DEFAULT = 8'h90
) (
    input  logic          clk,
    input  logic          rst_n,
    lut_eval_seq_if.slave bus
);
    localparam int          ENT  = 1 << N_IN;
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(ENT - 1);
    localparam logic [N_IN:0] ONE  = (N_IN + 1)'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t           state;
    logic [ENT-1:0]   act;
    logic [ENT-1:0]   sh;
    logic [ENT-1:0]   sh_merged;
    logic [N_IN:0]    cnt;
    logic             out_r;
    logic             out_valid_r;
    logic             cfg_done_r;
    logic             accept;
    logic             in_ready_c;

    assign in_ready_c = !out_valid_r || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_c;

    // The final beat is committed straight into the active table, so merge it here.
    always_comb begin
        sh_merged                   = sh;
        sh_merged[cnt[N_IN-1:0]]    = bus.cfg_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            act         <= TT_DEFAULT;
            sh          <= '0;
            cnt         <= '0;
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            cfg_done_r  <= 1'b0;
        end else begin
            cfg_done_r <= 1'b0;

            // Evaluation reads the pre-commit table even when a commit lands on this edge.
            if (accept) begin
                out_r       <= act[bus.in_vec];
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.cfg_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                        sh    <= '0;
                    end
                end
                LOAD: begin
                    if (bus.cfg_abort) begin
                        state <= IDLE;
                    end else if (bus.cfg_valid) begin
                        sh  <= sh_merged;
                        cnt <= cnt + ONE;
                        if (cnt == LAST) begin
                            act        <= sh_merged;
                            cfg_done_r <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.cfg_done  = cfg_done_r;
    assign bus.loading   = (state == LOAD);
    assign bus.cfg_ready = (state == LOAD);
endmodule

// File: tb/tb_lut_eval_seq.sv
// Self-checking bench for lut_eval_seq (N_IN=3) against a table-lookup reference model.
module tb_lut_eval_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [7:0] model_tbl;

    lut_eval_seq_if #(.N_IN(3)) bus ();

    lut_eval_seq #(.N_IN(3), .TT_DEFAULT(8'h90)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_abort = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'b0;
    endtask

    // Single accepted vector with out_ready high; returns what appears one cycle later.
    task automatic eval_vec(input logic [2:0] v, output logic o, output logic ov);
        bus.in_valid  = 1'b1;
        bus.in_vec    = v;
        bus.out_ready = 1'b1;
        step();
        o  = bus.out;
        ov = bus.out_valid;
        bus.in_valid = 1'b0;
    endtask

    // Full serial load with random gaps; counts cfg_done pulses and notes the one right after the last beat.
    task automatic do_load(input logic [7:0] t, output int dones, output logic done_after_last);
        dones = 0;
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.cfg_valid = 1'b0;
                step();
                if (bus.cfg_done) dones++;
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = t[k];
            bus.cfg_start = (k == 3);
            checks++;
            if (bus.cfg_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load_cfg_ready beat %0d: got %b, required 1", k, bus.cfg_ready);
            end
            step();
            if (bus.cfg_done) dones++;
        end
        done_after_last = bus.cfg_done;
        bus.cfg_valid = 1'b0;
        bus.cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.cfg_done) dones++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_stream: got ov=%b out=%b ir=%b, required 0 0 1",
                     bus.out_valid, bus.out, bus.in_ready);
        end
        checks++;
        if (bus.cfg_ready !== 1'b0 || bus.loading !== 1'b0 || bus.cfg_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cfg: got cr=%b ld=%b cd=%b, required 0 0 0",
                     bus.cfg_ready, bus.loading, bus.cfg_done);
        end
        step();
        rst_n = 1'b1;
        step();
        model_tbl = 8'h90;
    endtask

    task automatic test_default_stream();
        for (int v = 0; v < 8; v++) begin
            bus.in_valid  = 1'b1;
            bus.in_vec    = 3'(v);
            bus.out_ready = 1'b1;
            if (v == 0) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_pre_valid: got %b, required 0", bus.out_valid);
                end
            end
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== model_tbl[v]) begin
                errors++;
                $display("[TB] FAIL stream_default vec=%0d: got ov=%b out=%b, required 1 %b",
                         v, bus.out_valid, bus.out, model_tbl[v]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_drain: got ov=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid  = 1'b1;
        bus.in_vec    = 3'b111;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b1;
        bus.in_vec   = 3'b000;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== model_tbl[7] || bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold cyc=%0d: got ov=%b out=%b ir=%b, required 1 %b 0",
                         c, bus.out_valid, bus.out, bus.in_ready, model_tbl[7]);
            end
            step();
        end
        bus.out_ready = 1'b1;
        bus.in_vec    = 3'b100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL backpressure_release_ready: got %b, required 1", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== model_tbl[4]) begin
            errors++;
            $display("[TB] FAIL backpressure_b2b: got ov=%b out=%b, required 1 %b",
                     bus.out_valid, bus.out, model_tbl[4]);
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_commit_collision();
        logic o, ov;
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'b1;
            step();
        end
        bus.cfg_bit   = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_vec    = 3'b001;
        bus.out_ready = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.cfg_done !== 1'b1 || bus.out !== model_tbl[1] || bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_old_table: got cd=%b out=%b ov=%b, required 1 %b 1",
                     bus.cfg_done, bus.out, bus.out_valid, model_tbl[1]);
        end
        model_tbl = 8'hFF;
        eval_vec(3'b001, o, ov);
        checks++;
        if (o !== model_tbl[1] || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_new_table: got out=%b ov=%b, required %b 1", o, ov, model_tbl[1]);
        end
        step();
    endtask

    task automatic test_reload();
        int   dones;
        logic dl, o, ov;
        do_load(8'h96, dones, dl);
        model_tbl = 8'h96;
        checks++;
        if (dones != 1 || dl !== 1'b1 || bus.loading !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_done: got dones=%0d at_last=%b loading=%b, required 1 1 0",
                     dones, dl, bus.loading);
        end
        eval_vec(3'b011, o, ov);
        checks++;
        if (o !== model_tbl[3]) begin
            errors++;
            $display("[TB] FAIL reload_vec3: got %b, required %b", o, model_tbl[3]);
        end
        eval_vec(3'b111, o, ov);
        checks++;
        if (o !== model_tbl[7]) begin
            errors++;
            $display("[TB] FAIL reload_vec7: got %b, required %b", o, model_tbl[7]);
        end
        step();
    endtask

    task automatic test_abort();
        int   dones;
        logic dl, o, ov;
        logic [7:0] t;
        for (int pass = 0; pass < 2; pass++) begin
            dones = 0;
            bus.cfg_start = 1'b1;
            step();
            bus.cfg_start = 1'b0;
            for (int k = 0; k < ((pass == 0) ? 5 : 7); k++) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_bit   = 1'b1;
                step();
            end
            // Second pass aborts on the very beat that would have committed.
            bus.cfg_abort = 1'b1;
            bus.cfg_valid = (pass == 1);
            step();
            if (bus.cfg_done) dones++;
            bus.cfg_abort = 1'b0;
            bus.cfg_valid = 1'b0;
            step();
            if (bus.cfg_done) dones++;
            checks++;
            if (dones != 0 || bus.loading !== 1'b0 || bus.cfg_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_state pass=%0d: got dones=%0d ld=%b cr=%b, required 0 0 0",
                         pass, dones, bus.loading, bus.cfg_ready);
            end
            for (int v = 0; v < 8; v++) begin
                eval_vec(3'(v), o, ov);
                checks++;
                if (o !== model_tbl[v]) begin
                    errors++;
                    $display("[TB] FAIL abort_table pass=%0d vec=%0d: got %b, required %b",
                             pass, v, o, model_tbl[v]);
                end
            end
        end
        bus.cfg_abort = 1'b1;
        step();
        bus.cfg_abort = 1'b0;
        t = 8'($urandom);
        do_load(t, dones, dl);
        model_tbl = t;
        checks++;
        if (dones != 1 || dl !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_restart_done: got dones=%0d at_last=%b, required 1 1", dones, dl);
        end
        for (int v = 0; v < 8; v++) begin
            eval_vec(3'(v), o, ov);
            checks++;
            if (o !== model_tbl[v]) begin
                errors++;
                $display("[TB] FAIL abort_restart_table vec=%0d: got %b, required %b", v, o, model_tbl[v]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_load();
        logic o, ov;
        bus.in_valid  = 1'b1;
        bus.in_vec    = 3'b111;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid  = 1'b0;
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'b1;
            step();
        end
        bus.cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.loading !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_load: got ov=%b cr=%b ld=%b, required 0 0 0",
                     bus.out_valid, bus.cfg_ready, bus.loading);
        end
        step();
        rst_n = 1'b1;
        idle_inputs();
        step();
        model_tbl = 8'h90;
        for (int v = 0; v < 8; v++) begin
            eval_vec(3'(v), o, ov);
            checks++;
            if (o !== model_tbl[v] || ov !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_default_table vec=%0d: got out=%b ov=%b, required %b 1",
                         v, o, ov, model_tbl[v]);
            end
        end
        step();
    endtask

    // Random traffic against a one-slot result holder: a result is held until taken.
    task automatic test_random_stream();
        int   dones;
        logic dl;
        logic pend;
        logic val;
        logic exp_ready;
        logic acc;
        logic [7:0] t;
        t = 8'($urandom);
        do_load(t, dones, dl);
        model_tbl = t;
        pend = 1'b0;
        val  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_vec    = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !pend || bus.out_ready;
            acc       = bus.in_valid && exp_ready;
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL random_in_ready cyc=%0d: got %b, required %b", c, bus.in_ready, exp_ready);
            end
            if (acc) begin
                pend = 1'b1;
                val  = model_tbl[bus.in_vec];
            end else if (bus.out_ready) begin
                pend = 1'b0;
            end
            step();
            checks++;
            if (bus.out_valid !== pend || (pend && bus.out !== val)) begin
                errors++;
                $display("[TB] FAIL random_result cyc=%0d: got ov=%b out=%b, required %b %b",
                         c, bus.out_valid, bus.out, pend, val);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_tbl = 8'h90;
        test_reset();
        test_default_stream();
        test_backpressure();
        test_commit_collision();
        test_reload();
        test_abort();
        test_reset_mid_load();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_eval_seq.md
# lut_eval_seq

Parametrised, clocked successor to the fixed 3-input truth-table modules: an N-input Boolean function whose 2^N-entry truth table is programmable at run time through a serial load port and evaluated on a valid/ready stream. It sits between input sampling and the output reporter in the logic-circuit test harness. One build covers every rule-style function of the chosen width, and the table can be swapped without stalling evaluation.

## Interface
Parameters:
- N_IN, 3, number of Boolean inputs; legal range 1..6
- TT_DEFAULT, 8'h90 (width 2^N_IN), table loaded at reset; bit k is the output for input index k

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input vector offered
- in_ready  output  1  input vector accepted when in_valid && in_ready
- in_vec  input  N_IN  inputs; in_vec[N_IN-1] is in1 (index MSB)
- out_valid  output  1  result held
- out_ready  input  1  consumer takes the result
- out  output  1  function value
- cfg_start  input  1  single-cycle pulse that begins a table load
- cfg_abort  input  1  discards the load in progress
- cfg_valid  input  1  cfg_bit presented
- cfg_ready  output  1  high only in LOAD
- cfg_bit  input  1  serial table bit, entry 0 first
- cfg_done  output  1  one-cycle pulse on table commit
- loading  output  1  high in LOAD

## Operation
- Storage: active table ACT[2^N_IN-1:0] and shadow SH[2^N_IN-1:0]. Bit counter cnt has width N_IN+1.
- FSM states:
  - IDLE: default state. cfg_start -> LOAD with cnt=0 and SH cleared. cfg_start has no effect in any other state.
  - LOAD: each cfg_valid beat writes SH[cnt]=cfg_bit, then cnt+1.
    - Beat with cnt==2^N_IN-1: ACT<=SH with the final bit merged in, cfg_done=1 for one cycle, -> IDLE.
    - cfg_abort: -> IDLE, ACT unchanged, no cfg_done. cfg_abort wins over a same-cycle final beat. cfg_abort in IDLE is ignored.
- Evaluation runs in both states and always uses ACT.
  - in_ready = !out_valid || out_ready.
  - On accept: out <= ACT[in_vec], out_valid <= 1.
  - out_valid clears when out_ready is high and no new accept occurs in the same cycle.
- Commit and accept in the same cycle: the accepted vector sees the old ACT. The next accept sees the new table.
- out holds its value while out_valid && !out_ready. out holds its last value after the result is consumed.

## Timing
- Reset values (asynchronous assertion, synchronous release): ACT=TT_DEFAULT, SH=0, cnt=0, state IDLE, out=0, out_valid=0, cfg_done=0, loading=0, cfg_ready=0. in_ready=1.
- Evaluation latency is 1 cycle from accept to out_valid. Full throughput (1 result per cycle) when out_ready is held high.
- A load takes exactly 2^N_IN accepted cfg beats. cfg_done asserts in the cycle after the last beat, and ACT is updated on that same edge.
- cfg_valid gaps are legal; cnt holds while cfg_valid is low.
- Reset asserted mid-load: SH is lost, ACT returns to TT_DEFAULT, out_valid drops immediately.
- N_IN=6 gives 64 entries and a 7-bit cnt. No wrap-around is possible, because the FSM leaves LOAD at the terminal count.

## Test plan
- Reset defaults: N_IN=3. Stream in_vec 0..7 with out_ready=1. Required outs: 0,0,0,0,1,0,0,1, one per cycle, first result 1 cycle after the first accept.
- Backpressure: hold out_ready=0 after accepting in_vec=3'b111. Required: out_valid=1, out=1 stable, in_ready=0 for 5 cycles. Raising out_ready plus a new in_vec=3'b100 gives a back-to-back result of 1.
- Reload: cfg_start, then 8 beats encoding 8'h96 (parity). Required: cfg_done pulses once and loading falls. Afterwards in_vec=3'b011 gives 0 and in_vec=3'b111 gives 1.
- Commit collision: accept in_vec=3'b001 on the same cycle as the final cfg beat for 8'hFF. Required: result 0 (old table). The next accept of 3'b001 gives 1.
- Abort: cfg_start, 5 beats of 1, then cfg_abort. Required: no cfg_done, loading=0, table still 8'h90 (in_vec=3'b000 gives 0). A later cfg_start restarts at cnt=0.
- Reset mid-load: rst_n low after 3 beats while out_valid=1. Required: out_valid=0 and cfg_ready=0 immediately. After release the default table is active.
